// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// The master side drives operands and out_ready; the slave side is the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract built around one 4-bit carry-skip slice,
// processing one nibble per clock, least-significant nibble first.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-5:0] res_q;
    logic             carry_q, cout_q, ovf_q;
    logic [KW-1:0]    k_q;

    logic             accept, last;
    logic             in_ready_c, out_valid_c, busy_c;

    logic [3:0]       sl_a, sl_b, sl_p, sl_g, sl_sum;
    logic             sl_c1, sl_c2, sl_c3, sl_c4, sl_cout;

    assign accept = bus.in_valid && in_ready_c;
    assign last   = (k_q == KW'(NSLICE - 1));

    // 4-bit carry-skip slice: when every bit propagates, carry-in bypasses the ripple.
    always_comb begin : u_csla
        sl_a    = a_q[4*k_q +: 4];
        sl_b    = b_q[4*k_q +: 4];
        sl_p    = sl_a ^ sl_b;
        sl_g    = sl_a & sl_b;
        sl_c1   = sl_g[0] | (sl_p[0] & carry_q);
        sl_c2   = sl_g[1] | (sl_p[1] & sl_c1);
        sl_c3   = sl_g[2] | (sl_p[2] & sl_c2);
        sl_c4   = sl_g[3] | (sl_p[3] & sl_c3);
        sl_sum  = sl_p ^ {sl_c3, sl_c2, sl_c1, carry_q};
        sl_cout = (&sl_p) ? carry_q : sl_c4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        out_valid_c = (state_q == DONE);
        busy_c      = (state_q == RUN);
    end

    // Partial nibbles accumulate in res_q so the visible sum only moves on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < NSLICE - 1; i++) begin
                if (k_q == KW'(i)) res_q[4*i +: 4] <= sl_sum;
            end
            carry_q <= sl_cout;
            k_q     <= k_q + KW'(1);
            if (last) begin
                sum_q  <= {sl_sum, res_q};
                cout_q <= sl_cout;
                ovf_q  <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (sl_sum[3] ^ a_q[WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    res_t sb[$];

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [15:0] bb;
        logic [16:0] t;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {16'd0, cin ^ sub};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == bb[15]) && (r.sum[15] != a[15]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and leave right after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b required 1 within 20 cycles", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        sb.push_back(model(a, b, cin, sub));
    endtask

    // Wait for the result, compare against the scoreboard, then consume it.
    task automatic recv(output res_t got, output int lat, output int busy_cnt);
        res_t exp;
        lat = 0;
        busy_cnt = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy) busy_cnt++;
            step();
            lat++;
        end
        got = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        total++;
        if (bus.out_valid !== 1'b1 || got !== exp) begin
            bad++;
            $display("FAIL result: valid=%b sum=%h cout=%b ovf=%b required valid=1 sum=%h cout=%b ovf=%b",
                     bus.out_valid, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum} !== {5'b10000, 16'h0000}) begin
            bad++;
            $display("FAIL reset: rdy/vld/busy/cout/ovf=%b%b%b%b%b sum=%h required 10000 sum=0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        res_t got;
        int lat, bc;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        recv(got, lat, bc);
        total++;
        if (got !== '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0}) begin
            bad++;
            $display("FAIL add_const: sum=%h cout=%b ovf=%b required 5555 0 0", got.sum, got.cout, got.ovf);
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL latency: %0d required 4", lat);
        end
        total++;
        if (bc !== 4) begin
            bad++;
            $display("FAIL busy_cycles: %0d required 4", bc);
        end
    endtask

    task automatic test_carry_ovf_sub();
        res_t got;
        int lat, bc;
        logic [15:0] va[6] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
        logic [15:0] vb[6] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0007, 16'h0005};
        logic        vc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        res_t        ve[6] = '{'{16'h0000, 1'b1, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                               '{16'h8000, 1'b0, 1'b1}, '{16'h0000, 1'b1, 1'b1},
                               '{16'hFFFE, 1'b0, 1'b0}, '{16'h0001, 1'b1, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            send(va[i], vb[i], vc[i], vs[i]);
            recv(got, lat, bc);
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL vector%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                         i, got.sum, got.cout, got.ovf, ve[i].sum, ve[i].cout, ve[i].ovf);
            end
        end
    endtask

    task automatic test_random();
        res_t got;
        int lat, bc;
        for (int i = 0; i < 12; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            recv(got, lat, bc);
        end
    endtask

    task automatic test_back_to_back();
        res_t got, hold, exp;
        int lat, bc, n;
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        hold = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.sum, bus.cout, bus.ovf} !== hold) begin
                bad++;
                $display("FAIL stall%0d: valid=%b ready=%b sum=%h required valid=1 ready=0 sum=%h",
                         i, bus.out_valid, bus.in_ready, bus.sum, hold.sum);
            end
        end
        exp = sb.pop_front();
        total++;
        if (hold !== exp) begin
            bad++;
            $display("FAIL stalled_result: sum=%h required %h", hold.sum, exp.sum);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: in_ready=%b required 1", bus.in_ready);
        end
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        sb.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0));
        total++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_bubble: busy=%b valid=%b required busy=1 valid=0", bus.busy, bus.out_valid);
        end
        recv(got, lat, bc);
        total++;
        if (got.sum !== 16'h0002 || lat !== 4) begin
            bad++;
            $display("FAIL b2b_result: sum=%h lat=%0d required 0002 lat=4", got.sum, lat);
        end
    endtask

    task automatic test_reset_mid();
        res_t got;
        int lat, bc, seen;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        void'(sb.pop_back());
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum} !== {5'b10000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_mid: rdy/vld/busy/cout/ovf=%b%b%b%b%b sum=%h required 10000 sum=0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL aborted_valid: out_valid seen %0d cycles required 0", seen);
        end
        send(16'hABCD, 16'h1234, 1'b1, 1'b0);
        recv(got, lat, bc);
        total++;
        if (got.sum !== 16'hBE02) begin
            bad++;
            $display("FAIL post_reset: sum=%h required be02", got.sum);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        #2;
        test_reset();
        test_add();
        test_carry_ovf_sub();
        test_random();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
